// File: rtl/fifo_write_packer.sv
// Write-side packer for the 128-bit FIFO: gathers RATIO narrow beats per FIFO
// word and issues one registered write per word, never into a full FIFO.
module fifo_write_packer #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 128,
  parameter int RATIO = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_last,
  input  logic             fifo_full,
  output logic             wr_en,
  output logic [OUT_W-1:0] wr_data,
  output logic             pad_evt,
  output logic [CNT_W-1:0] words_cnt
);

  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  // Lanes below idx come from the accumulator, lane idx takes the beat and
  // lanes above idx are forced to zero (padding of a short packet).
  function automatic logic [OUT_W-1:0] merge_lane(
    input logic [OUT_W-1:0] acc,
    input logic [IDX_W-1:0] idx,
    input logic [IN_W-1:0]  beat
  );
    logic [OUT_W-1:0] w;
    w = '0;
    for (int j = 0; j < RATIO; j++) begin
      if (j < int'(idx)) begin
        w[j*IN_W +: IN_W] = acc[j*IN_W +: IN_W];
      end else if (j == int'(idx)) begin
        w[j*IN_W +: IN_W] = beat;
      end else begin
        w[j*IN_W +: IN_W] = '0;
      end
    end
    return w;
  endfunction

  logic [OUT_W-1:0] acc_r;
  logic [IDX_W-1:0] idx_r;
  logic [OUT_W-1:0] pend_r;
  logic             pend_valid_r;
  logic             pend_pad_r;
  logic             wr_en_r;
  logic [OUT_W-1:0] wr_data_r;
  logic             pad_evt_r;
  logic [CNT_W-1:0] words_cnt_r;

  logic             s_ready_s;
  logic             accept_s;
  logic             last_lane_s;
  logic             complete_s;
  logic             issue_s;
  logic [OUT_W-1:0] merged_s;

  // Handshake, word-completion and write-issue decode.
  always_comb begin
    s_ready_s   = reset && (!pend_valid_r || !fifo_full);
    accept_s    = s_valid && s_ready_s;
    last_lane_s = (idx_r == LAST_IDX);
    complete_s  = accept_s && (last_lane_s || s_last);
    issue_s     = pend_valid_r && !fifo_full;
    merged_s    = merge_lane(acc_r, idx_r, s_data);
  end

  // Accumulator and lane index; both restart after every completed word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r <= '0;
      idx_r <= '0;
    end else if (complete_s) begin
      acc_r <= '0;
      idx_r <= '0;
    end else if (accept_s) begin
      acc_r <= merged_s;
      idx_r <= idx_r + IDX_W'(1);
    end else begin
      acc_r <= acc_r;
      idx_r <= idx_r;
    end
  end

  // Holding register: a completing beat may reload it in the issuing cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_r       <= '0;
      pend_valid_r <= 1'b0;
      pend_pad_r   <= 1'b0;
    end else if (complete_s) begin
      pend_r       <= merged_s;
      pend_valid_r <= 1'b1;
      pend_pad_r   <= !last_lane_s;
    end else if (issue_s) begin
      pend_r       <= pend_r;
      pend_valid_r <= 1'b0;
      pend_pad_r   <= pend_pad_r;
    end else begin
      pend_r       <= pend_r;
      pend_valid_r <= pend_valid_r;
      pend_pad_r   <= pend_pad_r;
    end
  end

  // Registered FIFO write port and written-word counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en_r     <= 1'b0;
      wr_data_r   <= '0;
      pad_evt_r   <= 1'b0;
      words_cnt_r <= '0;
    end else begin
      wr_en_r   <= issue_s;
      wr_data_r <= pend_r;
      pad_evt_r <= pend_pad_r && issue_s;
      if (issue_s) begin
        words_cnt_r <= words_cnt_r + CNT_W'(1);
      end else begin
        words_cnt_r <= words_cnt_r;
      end
    end
  end

  assign s_ready   = s_ready_s;
  assign wr_en     = wr_en_r;
  assign wr_data   = wr_data_r;
  assign pad_evt   = pad_evt_r;
  assign words_cnt = words_cnt_r;

endmodule

// File: tb/tb_fifo_write_packer.sv
// Directed bench for fifo_write_packer: hand-computed words, padding,
// backpressure, reset mid-operation and counter values.
module tb_fifo_write_packer;

  logic         clk;
  logic         reset;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         s_last;
  logic         fifo_full;
  logic         wr_en;
  logic [127:0] wr_data;
  logic         pad_evt;
  logic [15:0]  words_cnt;

  int n_chk;
  int n_bad;
  int cyc;

  logic [127:0] wq[$];
  logic         wpad[$];
  int           wcyc[$];

  fifo_write_packer dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .fifo_full (fifo_full),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .pad_evt   (pad_evt),
    .words_cnt (words_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp writes.
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: wr_en is registered, so one negedge sample per pulse.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wq.push_back(wr_data);
      wpad.push_back(pad_evt);
      wcyc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Offer one beat and wait (bounded) for it to be accepted.
  task automatic send_beat(input logic [31:0] d, input logic l, output int stalls);
    int  n;
    logic took;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    n       = 0;
    took    = 1'b0;
    while (!took && n < 20) begin
      @(negedge clk);
      took = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    stalls = n - 1;
    check_eq("beat_accept", {127'd0, took}, 128'd1);
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    wq.delete();
    wpad.delete();
    wcyc.delete();
  endtask

  initial begin
    int st;
    int st_sum;
    logic [127:0] w;

    n_chk = 0; n_bad = 0; cyc = 0;
    reset = 1'b0; s_valid = 1'b0; s_data = 32'd0; s_last = 1'b0; fifo_full = 1'b0;

    // Reset state
    wait_cycles(3);
    check_eq("rst_s_ready", {127'd0, s_ready}, 128'd0);
    check_eq("rst_wr_en", {127'd0, wr_en}, 128'd0);
    check_eq("rst_wr_data", wr_data, 128'd0);
    check_eq("rst_pad", {127'd0, pad_evt}, 128'd0);
    check_eq("rst_cnt", {112'd0, words_cnt}, 128'd0);
    #2 reset = 1'b1;
    #1 check_eq("rel_s_ready", {127'd0, s_ready}, 128'd1);
    @(posedge clk); #1;

    // 1: full word, write one cycle after the 4th beat
    send_beat(32'h11111111, 1'b0, st);
    send_beat(32'h22222222, 1'b0, st);
    send_beat(32'h33333333, 1'b0, st);
    send_beat(32'h44444444, 1'b0, st);
    idle();
    check_eq("t1_no_early_wr", {127'd0, wr_en}, 128'd0);
    wait_cycles(1);
    check_eq("t1_wr_en", {127'd0, wr_en}, 128'd1);
    check_eq("t1_wr_data", wr_data, 128'h44444444_33333333_22222222_11111111);
    check_eq("t1_pad", {127'd0, pad_evt}, 128'd0);
    check_eq("t1_cnt", {112'd0, words_cnt}, 128'd1);
    wait_cycles(1);
    check_eq("t1_single_pulse", {127'd0, wr_en}, 128'd0);
    wait_cycles(1);
    clear_mon();

    // 2: short packet padded, next beat restarts in lane 0
    send_beat(32'hAAAA0001, 1'b0, st);
    send_beat(32'hAAAA0002, 1'b1, st);
    idle();
    wait_cycles(1);
    check_eq("t2_wr_en", {127'd0, wr_en}, 128'd1);
    check_eq("t2_wr_data", wr_data, 128'h00000000_00000000_AAAA0002_AAAA0001);
    check_eq("t2_pad", {127'd0, pad_evt}, 128'd1);
    check_eq("t2_cnt", {112'd0, words_cnt}, 128'd2);
    send_beat(32'hB0B0B0B0, 1'b0, st);
    send_beat(32'hB1B1B1B1, 1'b0, st);
    send_beat(32'hB2B2B2B2, 1'b0, st);
    send_beat(32'hB3B3B3B3, 1'b0, st);
    idle();
    wait_cycles(2);
    check_eq("t2_nwords", wq.size(), 128'd2);
    if (wq.size() > 1) begin
      check_eq("t2_lane0_word", wq[1], 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0);
      check_eq("t2_lane0_pad", {127'd0, wpad[1]}, 128'd0);
    end
    check_eq("t2_cnt3", {112'd0, words_cnt}, 128'd3);
    clear_mon();

    // 3: 16 back-to-back beats, no stalls, a write every 4 cycles
    st_sum = 0;
    for (int i = 0; i < 16; i++) begin
      send_beat(32'h10000000 + i, 1'b0, st);
      st_sum += st;
    end
    idle();
    wait_cycles(2);
    check_eq("t3_stalls", st_sum, 128'd0);
    check_eq("t3_nwords", wq.size(), 128'd4);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) w[j*32 +: 32] = 32'h10000000 + 4*k + j;
      if (k < wq.size()) check_eq("t3_word", wq[k], w);
      if (k > 0 && k < wcyc.size()) check_eq("t3_spacing", wcyc[k] - wcyc[k-1], 128'd4);
    end
    check_eq("t3_cnt", {112'd0, words_cnt}, 128'd7);
    clear_mon();

    // 4: FIFO full holds the first word and blocks further beats
    fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(32'hD0000000 + i, 1'b0, st);
    s_valid = 1'b1; s_data = 32'hD0000004; s_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t4_ready_low", {127'd0, s_ready}, 128'd0);
      @(posedge clk); #1;
    end
    check_eq("t4_no_wr", wq.size(), 128'd0);
    check_eq("t4_cnt_hold", {112'd0, words_cnt}, 128'd7);
    fifo_full = 1'b0;
    for (int i = 4; i < 8; i++) send_beat(32'hD0000000 + i, 1'b0, st);
    idle();
    wait_cycles(2);
    check_eq("t4_nwords", wq.size(), 128'd2);
    if (wq.size() > 1) begin
      check_eq("t4_word0", wq[0], 128'hD0000003_D0000002_D0000001_D0000000);
      check_eq("t4_word1", wq[1], 128'hD0000007_D0000006_D0000005_D0000004);
    end
    check_eq("t4_cnt", {112'd0, words_cnt}, 128'd9);
    clear_mon();

    // 5a: reset discards a held word
    fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(32'hE0000000 + i, 1'b0, st);
    idle();
    wait_cycles(1);
    #2 reset = 1'b0;
    #1 fifo_full = 1'b0;
    check_eq("t5_rst_cnt", {112'd0, words_cnt}, 128'd0);
    check_eq("t5_rst_ready", {127'd0, s_ready}, 128'd0);
    wait_cycles(2);
    #2 reset = 1'b1;
    wait_cycles(3);
    check_eq("t5_held_dropped", wq.size(), 128'd0);

    // 5b: reset after two beats of a word leaves no stale lanes
    send_beat(32'hF0000000, 1'b0, st);
    send_beat(32'hF0000001, 1'b0, st);
    idle();
    #2 reset = 1'b0;
    #1 check_eq("t5_wr_en", {127'd0, wr_en}, 128'd0);
    check_eq("t5_wr_data", wr_data, 128'd0);
    wait_cycles(2);
    #2 reset = 1'b1;
    wait_cycles(1);
    for (int i = 0; i < 4; i++) send_beat(32'hC0000000 + i, 1'b0, st);
    idle();
    wait_cycles(2);
    check_eq("t5_nwords", wq.size(), 128'd1);
    if (wq.size() > 0) begin
      check_eq("t5_word", wq[0], 128'hC0000003_C0000002_C0000001_C0000000);
      check_eq("t5_pad", {127'd0, wpad[0]}, 128'd0);
    end
    check_eq("t5_cnt", {112'd0, words_cnt}, 128'd1);
    clear_mon();

    // 6: s_last without s_valid ignored; s_last on lane 3 gives one unpadded word
    s_valid = 1'b0; s_last = 1'b1;
    wait_cycles(2);
    s_last = 1'b0;
    send_beat(32'h60000000, 1'b0, st);
    send_beat(32'h60000001, 1'b0, st);
    send_beat(32'h60000002, 1'b0, st);
    send_beat(32'h60000003, 1'b1, st);
    idle();
    wait_cycles(4);
    check_eq("t6_nwords", wq.size(), 128'd1);
    if (wq.size() > 0) begin
      check_eq("t6_word", wq[0], 128'h60000003_60000002_60000001_60000000);
      check_eq("t6_pad", {127'd0, wpad[0]}, 128'd0);
    end
    check_eq("t6_cnt", {112'd0, words_cnt}, 128'd2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
